ysyx_22040127_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the core's single memory port between up to NR_REQ requesters (IFU, LSU, CSR/debug). A winner is picked with a one-hot grant, its request is latched and issued on the shared port, and the response is routed back to that requester only. The port allows one outstanding transaction. The block sits between the pipeline front-end units and the memory/bus bridge.

---
 rtl/ysyx_22040127_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_ysyx_22040127_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040127_mem_arbiter.sv
// rtl/ysyx_22040127_mem_arbiter.sv - round-robin arbiter sharing one memory port among NR_REQ requesters
// One outstanding transaction; payload latched at grant, response routed back to the owner only.
module ysyx_22040127_mem_arbiter #(
  parameter int NR_REQ = 4,
  parameter int ID_W   = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NR_REQ-1:0]            req_valid,
  output logic [NR_REQ-1:0]            req_ready,
  input  logic [NR_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NR_REQ-1:0]            req_wen,
  input  logic [NR_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NR_REQ*DATA_W/8-1:0]   req_wmask,
  output logic [NR_REQ-1:0]            resp_valid,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_wen,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W/8-1:0]          mem_wmask,
  input  logic                         mem_resp_valid,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     winner;
  logic                found;
  logic                accept;
  logic                done;
  logic [2*NR_REQ-1:0] dbl;
  logic [NR_REQ-1:0]   rot;
  int                  cand;

  // Rotate req_valid so bit 0 is the requester right after last_grant, then take the first set bit.
  always_comb begin
    dbl    = {req_valid, req_valid} >> (int'(last_grant) + 1);
    rot    = dbl[NR_REQ-1:0];
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < NR_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        cand  = int'(last_grant) + 1 + k;
        if (cand >= NR_REQ) begin
          cand = cand - NR_REQ;
        end
        winner = cand[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          accept            = 1'b1;
          req_ready[winner] = 1'b1;
          state_nxt         = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          if (mem_resp_valid) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NR_REQ - 1);
      grant_id   <= '0;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= '0;
      if (accept) begin
        last_grant <= winner;
        grant_id   <= winner;
        mem_addr   <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
        mem_wen    <= req_wen[winner];
        mem_wdata  <= req_wdata[int'(winner)*DATA_W +: DATA_W];
        mem_wmask  <= req_wmask[int'(winner)*MASK_W +: MASK_W];
      end
      if (done) begin
        resp_valid[grant_id] <= 1'b1;
        resp_rdata           <= mem_rdata;
      end
    end
  end

  assign mem_req_valid = (state == ISSUE);
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_ysyx_22040127_mem_arbiter.sv
// tb/tb_ysyx_22040127_mem_arbiter.sv - directed and randomized checks of the round-robin memory arbiter
module tb_ysyx_22040127_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N-1:0]      req_wen = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N*MW-1:0]   req_wmask = '0;
  logic [N-1:0]      resp_valid;
  logic [DW-1:0]     resp_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [AW-1:0]     mem_addr;
  logic              mem_wen;
  logic [DW-1:0]     mem_wdata;
  logic [MW-1:0]     mem_wmask;
  logic              mem_resp_valid = 1'b0;
  logic [DW-1:0]     mem_rdata = '0;
  logic [1:0]        grant_id;
  logic              busy;

  ysyx_22040127_mem_arbiter #(.NR_REQ(N), .ID_W(2), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mdl_last = N - 1;
  int last_acc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = {$urandom, $urandom};
      req_wdata[i*DW +: DW] = {$urandom, $urandom};
      req_wmask[i*MW +: MW] = MW'($urandom);
    end
    req_wen = N'($urandom);
  endtask

  // Reference arbitration: first valid requester scanning upward circularly from last owner + 1.
  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(mdl_last + k) % N]) return (mdl_last + k) % N;
    end
    return -1;
  endfunction

  // Accept at the current IDLE cycle, stall ISSUE rdly cycles, then either complete in the
  // same cycle as the handshake or wait rspdly cycles in WAIT before the response.
  task automatic run_txn(input logic [N-1:0] vld, input int rdly, input bit same,
                         input int rspdly, input logic [63:0] rdat, output int gap);
    int w;
    logic [63:0] ea, ed, rd;
    logic [8:0]  ewm;
    req_valid = vld;
    #1;
    w = model_pick(vld);
    chk("req_ready_onehot", 64'(req_ready), 64'(1) << w);
    ea  = req_addr[w*AW +: AW];
    ed  = req_wdata[w*DW +: DW];
    ewm = {req_wen[w], req_wmask[w*MW +: MW]};
    mdl_last = w;
    gap = cyc - last_acc;
    last_acc = cyc;
    rd = '0;
    tick();
    for (int c = 0; c <= rdly; c++) begin
      req_valid = N'($urandom);
      rand_payload();
      mem_req_ready  = (c == rdly);
      mem_resp_valid = (c == rdly) ? same : 1'($urandom);
      mem_rdata      = (rdat != 0) ? rdat : {$urandom, $urandom};
      rd = mem_rdata;
      #1;
      chk("issue_mem_req_valid", 64'(mem_req_valid), 64'd1);
      chk("issue_mem_addr", mem_addr, ea);
      chk("issue_mem_wdata", mem_wdata, ed);
      chk("issue_wen_wmask", 64'({mem_wen, mem_wmask}), 64'(ewm));
      chk("issue_grant_id", 64'(grant_id), 64'(w));
      chk("issue_req_ready_zero", 64'(req_ready), 64'd0);
      chk("issue_resp_valid_zero", 64'(resp_valid), 64'd0);
      tick();
    end
    mem_req_ready = 1'b0;
    if (!same) begin
      for (int c = 0; c <= rspdly; c++) begin
        req_valid      = N'($urandom);
        mem_resp_valid = (c == rspdly);
        mem_rdata      = (rdat != 0) ? rdat : {$urandom, $urandom};
        rd = mem_rdata;
        #1;
        chk("wait_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("wait_busy", 64'(busy), 64'd1);
        chk("wait_req_ready_zero", 64'(req_ready), 64'd0);
        chk("wait_resp_valid_zero", 64'(resp_valid), 64'd0);
        tick();
      end
    end
    mem_resp_valid = 1'b0;
    req_valid = '0;
    chk("resp_valid_owner", 64'(resp_valid), 64'(1) << w);
    chk("resp_rdata", resp_rdata, rd);
    chk("resp_busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_grant_id"}, 64'(grant_id), 64'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_wen_wmask"}, 64'({mem_wen, mem_wmask}), 64'd0);
  endtask

  int gap;
  int order[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    // Reset state
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single read from requester 1
    rand_payload();
    req_addr[1*AW +: AW] = 64'h0000_0000_8000_0000;
    req_wen[1] = 1'b0;
    run_txn(4'b0010, 0, 1'b0, 0, 64'h0000_0000_DEAD_BEEF, gap);
    chk("read_grant_id", 64'(grant_id), 64'd1);

    // Fairness from a fresh reset, back-to-back with minimum latency
    rst_n = 1'b0;
    mdl_last = N - 1;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      run_txn(4'b1111, 0, 1'b0, 0, 64'd0, gap);
      chk("fair_order", 64'(grant_id), 64'(order[i]));
      if (i > 0) chk("fair_accept_gap", 64'(gap), 64'd3);
    end

    // Backpressure: five stalled ISSUE cycles with other requesters active
    run_txn(4'b0110, 5, 1'b0, 1, 64'd0, gap);

    // Masked write from requester 3
    rand_payload();
    req_wen[3] = 1'b1;
    req_wmask[3*MW +: MW] = 8'h0F;
    req_wdata[3*DW +: DW] = 64'h1122_3344_5566_7788;
    run_txn(4'b1000, 2, 1'b0, 2, 64'd0, gap);

    // Same-cycle ready and response
    run_txn(4'b0101, 0, 1'b1, 0, 64'd0, gap);
    tick();
    chk("same_cycle_stays_idle", 64'(busy), 64'd0);

    // Reset while in WAIT
    rand_payload();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    chk("pre_reset_in_wait", 64'({busy, mem_req_valid}), 64'b10);
    rst_n = 1'b0;
    mdl_last = N - 1;
    #1;
    check_all_zero("async_reset");
    mem_resp_valid = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("no_resp_after_reset", 64'(resp_valid), 64'd0);
    chk("idle_after_reset", 64'(busy), 64'd0);
    rand_payload();
    run_txn(4'b1111, 0, 1'b0, 0, 64'd0, gap);
    chk("first_after_reset", 64'(grant_id), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      rand_payload();
      run_txn(N'($urandom_range(1, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 64'd0, gap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
